// File: rtl/rect_offset_gen.sv
// Purpose : map VGA scan coordinates to an in-sprite offset and an inside flag,
//           with frame-latched position, mirror and blink controls.
// Latency : 1 clk from pixel to offsetX/offsetY/InsideRectangle; no backpressure (free-running pixel stream).
//
// Ports:
//   clk, resetN          pixel clock, asynchronous active-low reset
//   pixelX, pixelY       current scan coordinates (unsigned, 11 bit)
//   startOfFrame         one-cycle pulse on the first pixel of a frame
//   topLeftX, topLeftY   signed object corner, captured on startOfFrame
//   mirrorX, blinkEn     sprite controls, captured on startOfFrame
//   offsetX, offsetY     unscaled offset into the bitmap (0 when outside)
//   InsideRectangle      current pixel lies inside the drawn object
module rect_offset_gen #(
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int SCALE_SHIFT     = 0,
  parameter int BLINK_BIT       = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        mirrorX,
  input  logic        blinkEn,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle
);

  localparam int DRAW_W = OBJECT_WIDTH_X  << SCALE_SHIFT;
  localparam int DRAW_H = OBJECT_HEIGHT_Y << SCALE_SHIFT;

  // Frame-latched controls
  logic [10:0] r_lat_x;
  logic [10:0] r_lat_y;
  logic        r_mirror;
  logic        r_blink_en;
  logic [7:0]  r_frame_cnt;

  // Bypass: the startOfFrame pixel already sees the values being captured.
  logic [10:0] w_lat_x;
  logic [10:0] w_lat_y;
  logic        w_mirror;
  logic        w_blink_en;
  logic [7:0]  w_frame_cnt;

  assign w_lat_x     = startOfFrame ? topLeftX : r_lat_x;
  assign w_lat_y     = startOfFrame ? topLeftY : r_lat_y;
  assign w_mirror    = startOfFrame ? mirrorX  : r_mirror;
  assign w_blink_en  = startOfFrame ? blinkEn  : r_blink_en;
  assign w_frame_cnt = startOfFrame ? r_frame_cnt + 8'd1 : r_frame_cnt;

  // Pixel coordinates are unsigned, the corner is signed: extend each to 12 bits accordingly.
  logic signed [11:0] w_dx;
  logic signed [11:0] w_dy;

  assign w_dx = $signed({1'b0, pixelX}) - $signed({w_lat_x[10], w_lat_x});
  assign w_dy = $signed({1'b0, pixelY}) - $signed({w_lat_y[10], w_lat_y});

  logic w_in_x;
  logic w_in_y;
  logic w_blank;
  logic w_inside;

  // Sign bit clear means dx >= 0, so the upper bound can be checked unsigned.
  assign w_in_x  = !w_dx[11] && ($unsigned(w_dx) < 12'(DRAW_W));
  assign w_in_y  = !w_dy[11] && ($unsigned(w_dy) < 12'(DRAW_H));
  assign w_blank = w_blink_en && w_frame_cnt[BLINK_BIT];
  assign w_inside = w_in_x && w_in_y && !w_blank;

  logic [10:0] w_ux;
  logic [10:0] w_uy;
  logic [10:0] w_ux_final;

  assign w_ux       = 11'(w_dx >>> SCALE_SHIFT);
  assign w_uy       = 11'(w_dy >>> SCALE_SHIFT);
  assign w_ux_final = w_mirror ? (11'(OBJECT_WIDTH_X - 1) - w_ux) : w_ux;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lat_x         <= '0;
      r_lat_y         <= '0;
      r_mirror        <= 1'b0;
      r_blink_en      <= 1'b0;
      r_frame_cnt     <= '0;
      offsetX         <= '0;
      offsetY         <= '0;
      InsideRectangle <= 1'b0;
    end else begin
      r_lat_x     <= w_lat_x;
      r_lat_y     <= w_lat_y;
      r_mirror    <= w_mirror;
      r_blink_en  <= w_blink_en;
      r_frame_cnt <= w_frame_cnt;
      // Offsets are zeroed outside so nothing stale reaches the bitmap stage.
      InsideRectangle <= w_inside;
      offsetX         <= w_inside ? w_ux_final : 11'd0;
      offsetY         <= w_inside ? w_uy       : 11'd0;
    end
  end

endmodule

// File: tb/tb_rect_offset_gen.sv
// Purpose : directed self-checking bench for rect_offset_gen (scale 1x and 2x instances).
// Latency : expectations are queued when a pixel is driven and compared one clk later.
// Backpressure: none; the pixel stream is free-running.
module tb_rect_offset_gen;

  logic        clk;
  logic        resetN;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        mirrorX;
  logic        blinkEn;

  logic [10:0] ox0, oy0, ox1, oy1;
  logic        ins0, ins1;

  rect_offset_gen #(.OBJECT_WIDTH_X(32), .OBJECT_HEIGHT_Y(32), .SCALE_SHIFT(0), .BLINK_BIT(3)) u_dut_s0 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .mirrorX(mirrorX), .blinkEn(blinkEn),
    .offsetX(ox0), .offsetY(oy0), .InsideRectangle(ins0)
  );

  rect_offset_gen #(.OBJECT_WIDTH_X(32), .OBJECT_HEIGHT_Y(32), .SCALE_SHIFT(1), .BLINK_BIT(3)) u_dut_s1 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .mirrorX(mirrorX), .blinkEn(blinkEn),
    .offsetX(ox1), .offsetY(oy1), .InsideRectangle(ins1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          sel1;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel; optionally queue its expected result for the selected instance.
  task automatic step(input logic [10:0] x, input logic [10:0] y, input logic sof,
                      input bit do_chk, input bit sel1, input logic ins,
                      input logic [10:0] ox, input logic [10:0] oy, input string tag);
    exp_t e;
    @(negedge clk);
    pixelX = x;
    pixelY = y;
    startOfFrame = sof;
    if (do_chk) sb.push_back('{tag, sel1, ins, ox, oy});
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".ins"}, {10'd0, e.sel1 ? ins1 : ins0}, {10'd0, e.ins});
      chk({e.tag, ".ox"},  e.sel1 ? ox1 : ox0, e.ox);
      chk({e.tag, ".oy"},  e.sel1 ? oy1 : oy0, e.oy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // T1: reset held with active inputs (pixel inside the would-be object)
    resetN = 1'b0;
    pixelX = 11'd0; pixelY = 11'd0; startOfFrame = 1'b1;
    topLeftX = 11'd0; topLeftY = 11'd0; mirrorX = 1'b0; blinkEn = 1'b0;
    #3;
    chk("rst.ins0", {10'd0, ins0}, 11'd0);
    chk("rst.ox0", ox0, 11'd0);
    chk("rst.oy0", oy0, 11'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk.ins0", {10'd0, ins0}, 11'd0);
    startOfFrame = 1'b0;
    @(negedge clk);
    resetN = 1'b1;

    // T2: basic 1x, object at (100,50)
    topLeftX = 11'd100; topLeftY = 11'd50;
    step(11'd0,   11'd0,  1'b1, 1, 0, 1'b0, 11'd0,  11'd0,  "t2.sof_out");
    step(11'd100, 11'd50, 1'b0, 1, 0, 1'b1, 11'd0,  11'd0,  "t2.corner");
    step(11'd131, 11'd81, 1'b0, 1, 0, 1'b1, 11'd31, 11'd31, "t2.far");
    step(11'd132, 11'd50, 1'b0, 1, 0, 1'b0, 11'd0,  11'd0,  "t2.right_edge");
    step(11'd131, 11'd82, 1'b0, 1, 0, 1'b0, 11'd0,  11'd0,  "t2.bottom_edge");
    step(11'd99,  11'd50, 1'b0, 1, 0, 1'b0, 11'd0,  11'd0,  "t2.left_edge");
    step(11'd117, 11'd60, 1'b0, 1, 0, 1'b1, 11'd17, 11'd10, "t2.mid");

    // Reset asserted mid-line: outputs clear without waiting for a clock
    step(11'd101, 11'd52, 1'b0, 1, 0, 1'b1, 11'd1,  11'd2,  "t2.pre_rst");
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("midrst.ins0", {10'd0, ins0}, 11'd0);
    chk("midrst.ox0", ox0, 11'd0);
    chk("midrst.oy0", oy0, 11'd0);
    chk("midrst.ins1", {10'd0, ins1}, 11'd0);
    @(negedge clk);
    resetN = 1'b1;

    // T5: blink from a freshly reset counter; frames 1..263 with the object covering (0,0)
    topLeftX = 11'd0; topLeftY = 11'd0; mirrorX = 1'b0; blinkEn = 1'b1;
    for (int f = 1; f <= 263; f++) begin
      step(11'd0, 11'd0, 1'b1, 1, 0, (((f % 256) & 8) == 0), 11'd0, 11'd0, $sformatf("t5.f%0d", f));
    end
    step(11'd3, 11'd4, 1'b0, 1, 0, 1'b1, 11'd3, 11'd4, "t5.visible_mid");

    // T3: 2x scale, object at (10,10) drawn 64x64
    blinkEn = 1'b0;
    topLeftX = 11'd10; topLeftY = 11'd10;
    step(11'd10, 11'd10, 1'b1, 1, 1, 1'b1, 11'd0,  11'd0,  "t3.corner");
    step(11'd73, 11'd73, 1'b0, 1, 1, 1'b1, 11'd31, 11'd31, "t3.far");
    step(11'd74, 11'd10, 1'b0, 1, 1, 1'b0, 11'd0,  11'd0,  "t3.right_edge");
    step(11'd11, 11'd11, 1'b0, 1, 1, 1'b1, 11'd0,  11'd0,  "t3.sub_pixel");
    step(11'd12, 11'd13, 1'b0, 1, 1, 1'b1, 11'd1,  11'd1,  "t3.step2");
    step(11'd9,  11'd40, 1'b0, 1, 1, 1'b0, 11'd0,  11'd0,  "t3.left_edge");

    // T6: startOfFrame pixel is inside the new position only
    step(11'd300, 11'd200, 1'b0, 1, 0, 1'b0, 11'd0, 11'd0, "t6.old_pos");
    topLeftX = 11'd300; topLeftY = 11'd200;
    step(11'd300, 11'd200, 1'b1, 1, 0, 1'b1, 11'd0, 11'd0, "t6.bypass");

    // T4: mirror with negative X
    topLeftX = 11'h7F8; topLeftY = 11'd0; mirrorX = 1'b1;
    step(11'd0,  11'd0, 1'b1, 1, 0, 1'b1, 11'd23, 11'd0, "t4.mirror");
    step(11'd23, 11'd5, 1'b0, 1, 0, 1'b1, 11'd0,  11'd5, "t4.mirror_right");
    step(11'd24, 11'd5, 1'b0, 1, 0, 1'b0, 11'd0,  11'd0, "t4.right_edge");
    topLeftX = 11'd50; mirrorX = 1'b0;
    step(11'd0,  11'd0, 1'b0, 1, 0, 1'b1, 11'd23, 11'd0, "t4.midframe_hold");
    step(11'd0,  11'd0, 1'b1, 1, 0, 1'b0, 11'd0,  11'd0, "t4.new_frame");
    step(11'd50, 11'd0, 1'b0, 1, 0, 1'b1, 11'd0,  11'd0, "t4.new_corner");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
